regfile_loader: RTL

Byte-stream writer for the 16-entry × 8-bit register file. On `go`, it accepts DEPTH bytes over a valid/ready input, writes them to consecutive addresses, and optionally reads back each entry to confirm the write. It reports a checksum and an error flag, and pulses `done` when finished. It fills the register file before the scan/min/sum engine runs over it.

---
 rtl/regfile_loader_pkg.sv | 18 +
 rtl/regfile_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/regfile_loader_pkg.sv
// Shared definitions for the register-file loader: FSM states and default geometry.
package regfile_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_RD_REQ,
    S_RD_CAP,
    S_DONE
  } state_t;

  localparam int DEPTH_DEFAULT = 16;
  localparam int WIDTH_DEFAULT = 8;
  localparam int ADDR_W        = $clog2(DEPTH_DEFAULT);
  localparam int CSUM_W        = WIDTH_DEFAULT + 4;

endpackage

// File: rtl/regfile_loader.sv
// Byte-stream loader: accepts DEPTH bytes over valid/ready, writes them to
// consecutive register-file addresses, optionally reads each one back, and
// reports a running checksum plus a sticky first-mismatch error.
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter bit VERIFY = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     go,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     W_en,
  output logic [$clog2(DEPTH)-1:0] W_addr,
  output logic [WIDTH-1:0]         W_Data,
  output logic                     R_en,
  output logic [$clog2(DEPTH)-1:0] R_addr,
  input  logic [WIDTH-1:0]         R_Data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] err_addr,
  output logic [WIDTH+3:0]         checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = WIDTH + 4;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  // Sixteen bytes of at most 2^WIDTH-1 fit in WIDTH+4 bits, so a plain add
  // can never wrap.
  function automatic logic [CW-1:0] csum_add(input logic [CW-1:0] acc,
                                             input logic [WIDTH-1:0] b);
    return acc + CW'(b);
  endfunction

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] idx;
  logic          xfer;
  logic          last;

  assign xfer = (state == S_ACCEPT) && in_valid && in_ready;
  assign last = (idx == LAST);
  assign busy = (state != S_IDLE);

  // Next-state selection; the handshake, write, readback and index advance.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (go) state_nxt = S_ACCEPT;
      S_ACCEPT: if (xfer) state_nxt = S_WRITE;
      S_WRITE: begin
        if (VERIFY) state_nxt = S_RD_REQ;
        else        state_nxt = last ? S_DONE : S_ACCEPT;
      end
      S_RD_REQ: state_nxt = S_RD_CAP;
      S_RD_CAP: state_nxt = last ? S_DONE : S_ACCEPT;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register plus registered strobes decoded from the upcoming state.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      W_en     <= 1'b0;
      R_en     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == S_ACCEPT);
      W_en     <= (state_nxt == S_WRITE);
      R_en     <= (state_nxt == S_RD_REQ);
      done     <= (state_nxt == S_DONE);
    end
  end

  // Datapath: index, write/read addresses, held write byte, checksum, error.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      idx      <= '0;
      W_addr   <= '0;
      W_Data   <= '0;
      R_addr   <= '0;
      checksum <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            idx      <= '0;
            checksum <= '0;
            err      <= 1'b0;
            err_addr <= '0;
          end
        end
        S_ACCEPT: begin
          if (xfer) begin
            W_Data   <= in_data;
            W_addr   <= idx;
            checksum <= csum_add(checksum, in_data);
          end
        end
        S_WRITE: begin
          if (VERIFY)     R_addr <= idx;
          else if (!last) idx    <= idx + 1'b1;
        end
        S_RD_CAP: begin
          // Only the first mismatch is recorded; the run always completes.
          if ((R_Data != W_Data) && !err) begin
            err      <= 1'b1;
            err_addr <= idx;
          end
          if (!last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
